// File: rtl/fpu_ss_csr_sequencer.sv
// fpu_ss_csr_sequencer
//   Orders CSR accesses (fcsr/frm/fflags/fmode/fsrm) against in-flight FPU ops.
//   A CSR access waits in DRAIN until every in-flight FPU op has completed.
//   It is then handed to the CSR unit. One CSR_WAIT bubble follows, so the
//   next FPU issue already sees the updated rounding mode / fmode.
//
//   Optional feature: define FPU_SS_CSR_SEQ_STALL_STATS_EN to get a saturating
//   16-bit count of DRAIN cycles on stall_cycles_o. When it is undefined the
//   port is tied to 0.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   in_valid_i / in_ready_o        input buffer handshake (in_ready_o = pop)
//   in_is_csr_i, in_id_i           offered instruction is a CSR access; its ID
//   fpu_in_valid_o/fpu_in_ready_i  FPU issue handshake
//   fpu_out_valid_i/_ready_i       FPU completion handshake
//   csr_pop_valid_o, csr_id_o      CSR instruction handed to the CSR unit
//   outstanding_o                  in-flight FPU op count
//   busy_o                         not IDLE or ops in flight
//   err_o                          sticky: completion seen with count at 0
//   stall_cycles_o                 DRAIN cycle count (optional feature)
module fpu_ss_csr_sequencer #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_is_csr_i,
  input  logic [3:0]  in_id_i,
  output logic        fpu_in_valid_o,
  input  logic        fpu_in_ready_i,
  input  logic        fpu_out_valid_i,
  input  logic        fpu_out_ready_i,
  output logic        csr_pop_valid_o,
  output logic [3:0]  csr_id_o,
  output logic [3:0]  outstanding_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] stall_cycles_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, CSR_WAIT} state_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       err_q;
  logic       pop, issue, done;

  // Handshake outputs depend only on registered state/count and the offered
  // instruction, never on fpu_in_ready_i. They are gated by rst_ni so that
  // they fall to 0 as soon as reset is asserted.
  always_comb begin
    fpu_in_valid_o = 1'b0;
    pop            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (in_is_csr_i) pop = (cnt_q == 4'd0);
          else             fpu_in_valid_o = (cnt_q < MAX_CNT);
        end
      end
      DRAIN:    pop = in_valid_i && (cnt_q == 4'd0);
      default:  ;
    endcase
    if (!rst_ni) begin
      fpu_in_valid_o = 1'b0;
      pop            = 1'b0;
    end
  end

  assign issue           = fpu_in_valid_o && fpu_in_ready_i;
  assign done            = fpu_out_valid_i && fpu_out_ready_i;
  assign in_ready_o      = issue || pop;
  assign csr_pop_valid_o = pop;
  assign csr_id_o        = pop ? in_id_i : 4'd0;
  assign outstanding_o   = cnt_q;
  assign err_o           = err_q;
  assign busy_o          = (state_q != IDLE) || (cnt_q != 4'd0);

  // Sequencing FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i && in_is_csr_i)
            state_q <= (cnt_q == 4'd0) ? CSR_WAIT : DRAIN;
        end
        DRAIN: begin
          if (!in_valid_i)          state_q <= IDLE;
          else if (cnt_q == 4'd0)   state_q <= CSR_WAIT;
        end
        CSR_WAIT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // In-flight counter. Issue is blocked at MAX_CNT, so it cannot overflow.
  // A lone completion at 0 is an underflow: the count holds and err latches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else if (issue && !done) begin
      cnt_q <= cnt_q + 4'd1;
    end else if (done && !issue) begin
      if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      else               err_q <= 1'b1;
    end
  end

`ifdef FPU_SS_CSR_SEQ_STALL_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_q <= 16'd0;
    else if (state_q == DRAIN && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 16'd0;
`endif

endmodule

// File: tb/tb_fpu_ss_csr_sequencer.sv
module tb_fpu_ss_csr_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i, in_ready_o, in_is_csr_i;
  logic [3:0]  in_id_i;
  logic        fpu_in_valid_o, fpu_in_ready_i;
  logic        fpu_out_valid_i, fpu_out_ready_i;
  logic        csr_pop_valid_o;
  logic [3:0]  csr_id_o, outstanding_o;
  logic        busy_o, err_o;
  logic [15:0] stall_cycles_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef FPU_SS_CSR_SEQ_STALL_STATS_EN
  // DRAIN occupies cycles T+1..T+6 in the drain scenario below.
  localparam logic [15:0] EXP_STALL = 16'd6;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  fpu_ss_csr_sequencer #(.MAX_OUTSTANDING(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_is_csr_i(in_is_csr_i), .in_id_i(in_id_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_i(fpu_out_ready_i),
    .csr_pop_valid_o(csr_pop_valid_o), .csr_id_o(csr_id_o),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    in_valid_i = 1'b1; in_is_csr_i = 1'b0; in_id_i = 4'd0;
    fpu_in_ready_i = 1'b1; fpu_out_valid_i = 1'b0; fpu_out_ready_i = 1'b1;
    #3;
    // Reset state with an instruction offered
    chk("rst_fpu_valid", 16'(fpu_in_valid_o), 16'd0);
    chk("rst_in_ready",  16'(in_ready_o), 16'd0);
    chk("rst_cnt",       16'(outstanding_o), 16'd0);
    chk("rst_busy",      16'(busy_o), 16'd0);
    chk("rst_err",       16'(err_o), 16'd0);
    chk("rst_stall",     stall_cycles_o, 16'd0);
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_ni = 1'b1;
    #1;
    // Back-to-back issue right after release
    chk("b2b_valid", 16'(fpu_in_valid_o), 16'd1);
    chk("b2b_ready", 16'(in_ready_o), 16'd1);
    tick(); tick(); tick();
    chk("b2b_cnt3", 16'(outstanding_o), 16'd3);
    tick();
    chk("max_cnt4",     16'(outstanding_o), 16'd4);
    chk("max_blocked",  16'(fpu_in_valid_o), 16'd0);
    chk("max_no_ready", 16'(in_ready_o), 16'd0);
    chk("max_busy",     16'(busy_o), 16'd1);

    // Retire two ops -> count 2
    in_valid_i = 1'b0; fpu_out_valid_i = 1'b1;
    tick(); tick();
    fpu_out_valid_i = 1'b0;
    chk("retire_cnt2", 16'(outstanding_o), 16'd2);

    // Drain scenario: CSR offered at T with count 2, completions at T+3, T+5
    in_valid_i = 1'b1; in_is_csr_i = 1'b1; in_id_i = 4'd5;
    #1;
    chk("T_no_pop",   16'(csr_pop_valid_o), 16'd0);
    chk("T_no_ready", 16'(in_ready_o), 16'd0);
    chk("T_id0",      16'(csr_id_o), 16'd0);
    tick();                                          // T+1
    chk("drain_no_issue", 16'(fpu_in_valid_o), 16'd0);
    chk("drain_busy",     16'(busy_o), 16'd1);
    tick();                                          // T+2
    tick();                                          // T+3
    fpu_out_valid_i = 1'b1;
    tick();                                          // T+4
    fpu_out_valid_i = 1'b0;
    chk("drain_cnt1", 16'(outstanding_o), 16'd1);
    tick();                                          // T+5
    fpu_out_valid_i = 1'b1;
    #1;
    chk("T5_no_pop", 16'(csr_pop_valid_o), 16'd0);
    tick();                                          // T+6
    fpu_out_valid_i = 1'b0;
    #1;
    chk("T6_pop",   16'(csr_pop_valid_o), 16'd1);
    chk("T6_id",    16'(csr_id_o), 16'd5);
    chk("T6_ready", 16'(in_ready_o), 16'd1);
    chk("T6_cnt0",  16'(outstanding_o), 16'd0);
    tick();                                          // T+7 CSR_WAIT
    in_is_csr_i = 1'b0; in_id_i = 4'd0;
    #1;
    chk("T7_no_issue", 16'(fpu_in_valid_o), 16'd0);
    chk("T7_no_ready", 16'(in_ready_o), 16'd0);
    chk("T7_no_pop",   16'(csr_pop_valid_o), 16'd0);
    chk("T7_busy",     16'(busy_o), 16'd1);
    tick();                                          // T+8
    chk("T8_issue", 16'(fpu_in_valid_o), 16'd1);
    chk("T8_ready", 16'(in_ready_o), 16'd1);
    chk("stall",    stall_cycles_o, EXP_STALL);
    tick();                                          // count 1

    // Simultaneous issue + completion at count 1
    fpu_out_valid_i = 1'b1;
    tick();
    chk("simul_cnt1", 16'(outstanding_o), 16'd1);
    in_valid_i = 1'b0;
    tick();
    chk("ret_cnt0", 16'(outstanding_o), 16'd0);
    // Simultaneous at count 0: no underflow
    in_valid_i = 1'b1;
    tick();
    chk("simul0_cnt", 16'(outstanding_o), 16'd0);
    chk("simul0_err", 16'(err_o), 16'd0);
    // Lone completion at count 0: err latches
    in_valid_i = 1'b0;
    tick();
    chk("uflow_cnt", 16'(outstanding_o), 16'd0);
    chk("uflow_err", 16'(err_o), 16'd1);
    fpu_out_valid_i = 1'b0;
    tick();
    chk("err_sticky", 16'(err_o), 16'd1);

    // CSR at count 0: immediate pop, one bubble, then issue
    in_valid_i = 1'b1; in_is_csr_i = 1'b1; in_id_i = 4'hA;
    #1;
    chk("imm_pop",      16'(csr_pop_valid_o), 16'd1);
    chk("imm_id",       16'(csr_id_o), 16'hA);
    chk("imm_ready",    16'(in_ready_o), 16'd1);
    chk("imm_no_issue", 16'(fpu_in_valid_o), 16'd0);
    tick();
    in_is_csr_i = 1'b0; in_id_i = 4'd0;
    #1;
    chk("bubble_no_issue", 16'(fpu_in_valid_o), 16'd0);
    tick();
    chk("post_bubble_issue", 16'(fpu_in_valid_o), 16'd1);
    tick(); tick(); tick();
    chk("pre_rst_cnt3", 16'(outstanding_o), 16'd3);

    // Reset mid-DRAIN at count 3
    in_is_csr_i = 1'b1; in_id_i = 4'd3;
    tick();
    chk("drain2_no_ready", 16'(in_ready_o), 16'd0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_cnt",   16'(outstanding_o), 16'd0);
    chk("arst_busy",  16'(busy_o), 16'd0);
    chk("arst_valid", 16'(fpu_in_valid_o), 16'd0);
    chk("arst_ready", 16'(in_ready_o), 16'd0);
    chk("arst_pop",   16'(csr_pop_valid_o), 16'd0);
    chk("arst_err",   16'(err_o), 16'd0);
    chk("arst_stall", stall_cycles_o, 16'd0);
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    #1;
    chk("rel_pop",   16'(csr_pop_valid_o), 16'd1);
    chk("rel_ready", 16'(in_ready_o), 16'd1);
    chk("rel_id",    16'(csr_id_o), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
